dino_tick_sched: RTL and testbench

//  Game-timing controller between the clock divider and the game logic. Consumes the

---
 rtl/dino_tick_sched.sv | 171 +++++++++++++++++
 tb/tb_dino_tick_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dino_tick_sched.sv
// Game-timing controller: tick-driven IDLE/RUN/PAUSE/OVER FSM producing score/scroll strobes and speed ramp.
// Latency: every output is registered; strobes appear 1 clk after the causing tick or button edge.
// Backpressure: none; ticks arriving while not in RUN (or pre-empted by collision/pause) are dropped.
// Optional: define SCHED_TURBO_EN to add the turbo input (halves the step divisor, floor 2, while in RUN).
module dino_tick_sched #(
   parameter int BASE_DIV    = 20,
   parameter int DIV_STEP    = 2,
   parameter int MIN_DIV     = 6,
   parameter int LEVEL_TICKS = 100,
   parameter int MAX_LEVEL   = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       score_tick,
   input  logic       fast_tick,
   input  logic       blink_tick,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic       collision,
`ifdef SCHED_TURBO_EN
   input  logic       turbo,
`endif
   output logic [1:0] state,
   output logic       score_clr,
   output logic       score_inc,
   output logic       world_step,
   output logic [3:0] speed_level,
   output logic       display_on
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        start_q, pause_q;
   logic [7:0]  step_cnt_q, step_cnt_d;
   logic [15:0] lvl_cnt_q, lvl_cnt_d;
   logic [3:0]  speed_q, speed_d;
   logic        disp_q, disp_d;
   logic        clr_q, clr_d;
   logic        inc_q, inc_d;
   logic        wstep_q, wstep_d;

   logic        start_edge, pause_edge;
   logic [15:0] lvl_prod;
   logic [7:0]  div_base, div_eff;

   assign start_edge  = btn_start & ~start_q;
   assign pause_edge  = btn_pause & ~pause_q;

   assign state       = state_q;
   assign score_clr   = clr_q;
   assign score_inc   = inc_q;
   assign world_step  = wstep_q;
   assign speed_level = speed_q;
   assign display_on  = disp_q;

   // Step divisor for the current speed level, clamped at MIN_DIV without underflow.
   always_comb begin
      lvl_prod = 16'(speed_q) * 16'(DIV_STEP);
      if (lvl_prod + 16'(MIN_DIV) >= 16'(BASE_DIV)) begin
         div_base = 8'(MIN_DIV);
      end else begin
         div_base = 8'(16'(BASE_DIV) - lvl_prod);
      end
`ifdef SCHED_TURBO_EN
      if (turbo) begin
         div_eff = ((div_base >> 1) < 8'd2) ? 8'd2 : (div_base >> 1);
      end else begin
         div_eff = div_base;
      end
`else
      div_eff = div_base;
`endif
   end

   // Next-state and next-output logic of the game FSM.
   always_comb begin
      state_d    = state_q;
      step_cnt_d = step_cnt_q;
      lvl_cnt_d  = lvl_cnt_q;
      speed_d    = speed_q;
      disp_d     = disp_q;
      clr_d      = 1'b0;
      inc_d      = 1'b0;
      wstep_d    = 1'b0;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_edge) begin
               state_d    = S_RUN;
               clr_d      = 1'b1;
               speed_d    = 4'd0;
               step_cnt_d = 8'd0;
               lvl_cnt_d  = 16'd0;
               disp_d     = 1'b1;
            end else if (blink_tick) begin
               disp_d = ~disp_q;
            end
         end
         S_RUN: begin
            disp_d = 1'b1;
            if (collision) begin
               state_d = S_OVER;
            end else if (pause_edge) begin
               state_d = S_PAUSE;
            end else begin
               if (score_tick) begin
                  inc_d = 1'b1;
                  if (lvl_cnt_q >= 16'(LEVEL_TICKS - 1)) begin
                     lvl_cnt_d = 16'd0;
                     if (speed_q < 4'(MAX_LEVEL)) begin
                        speed_d = speed_q + 4'd1;
                     end
                  end else begin
                     lvl_cnt_d = lvl_cnt_q + 16'd1;
                  end
               end
               // >= so a level-up that shrinks the divisor below the count fires on the next tick
               if (fast_tick) begin
                  if (step_cnt_q >= div_eff - 8'd1) begin
                     wstep_d    = 1'b1;
                     step_cnt_d = 8'd0;
                  end else begin
                     step_cnt_d = step_cnt_q + 8'd1;
                  end
               end
            end
         end
         S_PAUSE: begin
            if (pause_edge) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counter, output and button-sample registers; reset dominates.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         start_q    <= 1'b0;
         pause_q    <= 1'b0;
         step_cnt_q <= 8'd0;
         lvl_cnt_q  <= 16'd0;
         speed_q    <= 4'd0;
         disp_q     <= 1'b1;
         clr_q      <= 1'b0;
         inc_q      <= 1'b0;
         wstep_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= btn_start;
         pause_q    <= btn_pause;
         step_cnt_q <= step_cnt_d;
         lvl_cnt_q  <= lvl_cnt_d;
         speed_q    <= speed_d;
         disp_q     <= disp_d;
         clr_q      <= clr_d;
         inc_q      <= inc_d;
         wstep_q    <= wstep_d;
      end
   end

endmodule

// File: tb/tb_dino_tick_sched.sv
// Bench for dino_tick_sched: random tick/button/collision traffic against a reference model.
// Expected outputs are queued per cycle by the driver; a negedge monitor pops and compares.
// Turbo input is exercised only when SCHED_TURBO_EN is defined.
module tb_dino_tick_sched;

   localparam int BASE_DIV    = 20;
   localparam int DIV_STEP    = 2;
   localparam int MIN_DIV     = 6;
   localparam int LEVEL_TICKS = 100;
   localparam int MAX_LEVEL   = 7;

   logic       clk = 1'b0;
   logic       rst, score_tick, fast_tick, blink_tick, btn_start, btn_pause, collision, turbo;
   logic [1:0] state;
   logic       score_clr, score_inc, world_step, display_on;
   logic [3:0] speed_level;

   always #5 clk = ~clk;

   dino_tick_sched #(
      .BASE_DIV(BASE_DIV), .DIV_STEP(DIV_STEP), .MIN_DIV(MIN_DIV),
      .LEVEL_TICKS(LEVEL_TICKS), .MAX_LEVEL(MAX_LEVEL)
   ) dut (
      .clk(clk), .rst(rst), .score_tick(score_tick), .fast_tick(fast_tick),
      .blink_tick(blink_tick), .btn_start(btn_start), .btn_pause(btn_pause),
      .collision(collision),
`ifdef SCHED_TURBO_EN
      .turbo(turbo),
`endif
      .state(state), .score_clr(score_clr), .score_inc(score_inc),
      .world_step(world_step), .speed_level(speed_level), .display_on(display_on)
   );

   // expected vector: {state, score_clr, score_inc, world_step, speed_level, display_on}
   logic [9:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   // reference model state (game-level quantities, plain integers)
   int m_state = 0;
   int m_level = 0;
   int m_score_in_level = 0;
   int m_ticks_since_step = 0;
   bit m_disp = 1'b1;
   bit m_prev_start = 1'b0;
   bit m_prev_pause = 1'b0;
   bit bst = 1'b0;
   bit bpa = 1'b0;
   bit btu = 1'b0;

   function automatic int step_interval(int lvl, bit tur);
      int d;
      d = BASE_DIV - lvl * DIV_STEP;
      if (d < MIN_DIV) d = MIN_DIV;
      if (tur) begin
         d = d / 2;
         if (d < 2) d = 2;
      end
      return d;
   endfunction

   // Apply one cycle of inputs, predict the outputs seen after the next edge, queue them.
   task automatic drive(input bit r, input bit st, input bit pa, input bit col,
                        input bit sc, input bit ft, input bit bl, input bit tu);
      bit se, pe, clr, inc, stp, tur;
      rst = r; btn_start = st; btn_pause = pa; collision = col;
      score_tick = sc; fast_tick = ft; blink_tick = bl; turbo = tu;
`ifdef SCHED_TURBO_EN
      tur = tu;
`else
      tur = 1'b0;
`endif
      clr = 0; inc = 0; stp = 0;
      if (r) begin
         m_state = 0; m_level = 0; m_score_in_level = 0; m_ticks_since_step = 0;
         m_disp = 1; m_prev_start = 0; m_prev_pause = 0;
      end else begin
         se = st && !m_prev_start;
         pe = pa && !m_prev_pause;
         m_prev_start = st;
         m_prev_pause = pa;
         if (m_state == 0 || m_state == 3) begin
            if (se) begin
               m_state = 1; clr = 1; m_level = 0; m_score_in_level = 0;
               m_ticks_since_step = 0; m_disp = 1;
            end else if (bl) begin
               m_disp = !m_disp;
            end
         end else if (m_state == 1) begin
            m_disp = 1;
            if (col) m_state = 3;
            else if (pe) m_state = 2;
            else begin
               int interval;
               interval = step_interval(m_level, tur);
               if (sc) begin
                  inc = 1;
                  m_score_in_level++;
                  if (m_score_in_level == LEVEL_TICKS) begin
                     m_score_in_level = 0;
                     if (m_level < MAX_LEVEL) m_level++;
                  end
               end
               if (ft) begin
                  m_ticks_since_step++;
                  if (m_ticks_since_step >= interval) begin
                     stp = 1;
                     m_ticks_since_step = 0;
                  end
               end
            end
         end else begin
            if (pe) m_state = 1;
         end
      end
      exp_q.push_back({2'(m_state), clr, inc, stp, 4'(m_level), m_disp});
      @(posedge clk);
      #1;
   endtask

   function automatic bit chance(int per10k);
      return $urandom_range(9999) < per10k;
   endfunction

   // Random traffic: buttons are held levels flipped with small probability.
   task automatic run_phase(input int n, input int p_st, input int p_pa, input int p_col,
                            input int p_sc, input int p_ft, input int p_bl, input int p_rst,
                            input int p_tu);
      for (int i = 0; i < n; i++) begin
         if (chance(p_st)) bst = !bst;
         if (chance(p_pa)) bpa = !bpa;
         if (chance(p_tu)) btu = !btu;
         drive(chance(p_rst), bst, bpa, chance(p_col), chance(p_sc), chance(p_ft),
               chance(p_bl), btu);
      end
   endtask

   // Monitor: compare the DUT outputs of every cycle with the queued prediction.
   initial begin
      logic [9:0] e, got;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {state, score_clr, score_inc, world_step, speed_level, display_on};
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL outputs t=%0t got st=%0d clr=%b inc=%b step=%b lvl=%0d disp=%b required st=%0d clr=%b inc=%b step=%b lvl=%0d disp=%b",
                        $time, got[9:8], got[7], got[6], got[5], got[4:1], got[0],
                        e[9:8], e[7], e[6], e[5], e[4:1], e[0]);
            end
         end
      end
   end

   // Stimulus: directed opening, then random phases of increasing hostility.
   initial begin
      int guard;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      // idle blinking, then a start press held for several cycles
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 1, 0);
      bst = 1;
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 0, 0);
      bst = 0;
      // 40 fast ticks at level 0: steps after the 20th and 40th
      for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 0, 1, 0, 0);
      // pause at step count 10, pausing swallows ticks, then resume
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, 1, 0, 0);
      bpa = 1; drive(0, 0, 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 50; i++) drive(0, 0, 1, 0, 1, 1, 1, 0);
      bpa = 0; drive(0, 0, 0, 0, 0, 0, 0, 0);
      bpa = 1; drive(0, 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) drive(0, 0, 1, 0, 0, 1, 0, 0);
      bpa = 0;
      // collision coincident with ticks, blink in OVER, restart
      drive(0, 0, 0, 1, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 1, 0);
      bst = 1; drive(0, 1, 1, 0, 0, 0, 0, 0);
      bst = 0; drive(0, 0, 0, 0, 0, 0, 0, 0);
      // long run with no collisions: speed ramps to saturation
      run_phase(10000, 20, 10, 0, 3000, 6000, 500, 0, 50);
      // reset mid-run
      drive(1, bst, bpa, 0, 1, 1, 1, btu);
      bst = 1; drive(0, 1, bpa, 0, 0, 0, 0, btu);
      run_phase(8000, 500, 100, 30, 3000, 5000, 500, 3, 200);
      run_phase(2000, 3000, 3000, 1000, 5000, 5000, 3000, 50, 3000);
      for (int i = 0; i < 4; i++) drive(0, bst, bpa, 0, 0, 0, 0, 0);
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
